// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: bus width, register
// offsets relative to BASE_ADDR, FSM state encoding and the well-known
// source indices of the upstream timer/GPIO block.
package irq_controller_pkg;

  localparam int DATA_W = 8;

  // Register offsets from BASE_ADDR
  localparam logic [DATA_W-1:0] IRQ_IE   = 8'd0;
  localparam logic [DATA_W-1:0] IRQ_IF   = 8'd1;
  localparam logic [DATA_W-1:0] IRQ_EDGE = 8'd2;
  localparam logic [DATA_W-1:0] IRQ_CTRL = 8'd3;
  localparam logic [DATA_W-1:0] IRQ_VEC  = 8'd4;
  localparam logic [DATA_W-1:0] IRQ_EOI  = 8'd5;

  // Source bit positions driven by the timer block
  localparam int SRC_TOP   = 0;
  localparam int SRC_CMPR0 = 1;
  localparam int SRC_CMPR1 = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  // True when a bus offset (address - BASE_ADDR, wrapping) lands in the map.
  // Addresses below the base wrap to large offsets and so fall outside.
  function automatic logic irq_in_map(input logic [DATA_W-1:0] off);
    return off <= IRQ_EOI;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
// Ports:
//   req   : request vector, one bit per source
//   idx   : index of the lowest set bit (0 when none set)
//   valid : at least one request bit is set
module irq_prio_enc #(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [2:0]         idx,
  output logic               valid
);

  // Scan from the top down so the last hit is the lowest index.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller on the 8-bit I/O bus. Captures event flags from the
// timer/GPIO block (edge or level per source), masks them, and presents one
// prioritised request plus vector to the CPU with an ack / EOI handshake.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   address, din      : I/O bus address and write data
//   w_en, r_en        : write / read strobes, sampled at posedge
//   dout              : registered read data, holds between reads
//   irq_src           : raw event inputs, synchronous to clk
//   irq_ack           : CPU accept pulse (only honoured while requesting)
//   irq_req           : request to the CPU
//   irq_vector        : index of the source requested / being serviced
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int               NUM_SRC   = 8,
  parameter logic [DATA_W-1:0] BASE_ADDR = 8'h10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  address,
  input  logic [DATA_W-1:0]  din,
  input  logic               w_en,
  input  logic               r_en,
  output logic [DATA_W-1:0]  dout,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               irq_ack,
  output logic               irq_req,
  output logic [2:0]         irq_vector
);

  logic [DATA_W-1:0]  off;
  logic               hit;
  logic               wr_ie, wr_if, wr_edge, wr_ctrl, wr_eoi, rd;

  logic [NUM_SRC-1:0] ie, pend, edge_sel, prev_src_p1;
  logic               gie;
  irq_state_e         state_q, state_d;
  logic [2:0]         vec_q, vec_d;

  logic [NUM_SRC-1:0] set_ev, w1c, ack_clr, pend_d, ie_d, cand, cand_d;
  logic               gie_d;
  logic               ack_take;
  logic [2:0]         win_idx;
  logic               win_vld;
  logic [DATA_W-1:0]  rd_data;

  // ---- Bus decode ----
  assign off     = address - BASE_ADDR;
  assign hit     = irq_in_map(off);
  assign wr_ie   = w_en && hit && (off == IRQ_IE);
  assign wr_if   = w_en && hit && (off == IRQ_IF);
  assign wr_edge = w_en && hit && (off == IRQ_EDGE);
  assign wr_ctrl = w_en && hit && (off == IRQ_CTRL);
  assign wr_eoi  = w_en && hit && (off == IRQ_EOI);
  assign rd      = r_en && hit;

  // ---- Capture and flag update ----
  assign ack_take = (state_q == ST_REQ) && irq_ack;
  assign set_ev   = (irq_src & ~prev_src_p1 & edge_sel) | (irq_src & ~edge_sel);
  assign w1c      = wr_if ? din[NUM_SRC-1:0] : '0;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_clr[i] = ack_take && (vec_q == 3'(i));
    end
  end

  // New events are OR-ed in last, so a capture always beats a clear on the
  // same bit in the same cycle.
  assign pend_d = (pend & ~w1c & ~ack_clr) | set_ev;
  assign ie_d   = wr_ie ? din[NUM_SRC-1:0] : ie;
  assign cand   = pend & ie;
  assign cand_d = pend_d & ie_d;

  // Hardware events override a simultaneous software write to CTRL.
  always_comb begin
    gie_d = gie;
    if (wr_ctrl) gie_d = din[0];
    if (wr_eoi && (state_q == ST_SERVICE)) gie_d = 1'b1;
    if (ack_take) gie_d = 1'b0;
  end

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio (
    .req   (cand),
    .idx   (win_idx),
    .valid (win_vld)
  );

  // ---- Read mux ----
  always_comb begin
    rd_data = '0;
    case (off)
      IRQ_IE:   rd_data = DATA_W'(ie);
      IRQ_IF:   rd_data = DATA_W'(pend);
      IRQ_EDGE: rd_data = DATA_W'(edge_sel);
      IRQ_CTRL: rd_data = DATA_W'(gie);
      IRQ_VEC:  rd_data = DATA_W'(vec_q);
      default:  rd_data = '0;
    endcase
  end

  // ---- FSM next state ----
  // In REQ the withdrawal check looks at the flag/mask values being written
  // this cycle, so a W1C or IE clear drops irq_req on the very next cycle.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      ST_IDLE: begin
        if (gie && win_vld) begin
          state_d = ST_REQ;
          vec_d   = win_idx;
        end
      end
      ST_REQ: begin
        if (irq_ack)               state_d = ST_SERVICE;
        else if (!cand_d[vec_q])   state_d = ST_IDLE;
      end
      ST_SERVICE: begin
        if (wr_eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- FSM state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  // ---- Register file, capture stage and read data ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ie          <= '0;
      pend        <= '0;
      edge_sel    <= '0;
      gie         <= 1'b0;
      prev_src_p1 <= '0;
      dout        <= '0;
    end else begin
      ie          <= ie_d;
      pend        <= pend_d;
      gie         <= gie_d;
      prev_src_p1 <= irq_src;
      if (wr_edge) edge_sel <= din[NUM_SRC-1:0];
      if (rd)      dout     <= rd_data;
    end
  end

  assign irq_req    = (state_q == ST_REQ);
  assign irq_vector = vec_q;

endmodule
